// File: rtl/program_loader.sv
// program_loader: streams a program image into instruction memory and holds the core in reset
// until the image is complete. Define PROGRAM_LOADER_VERIFY_EN for XOR-checksum readback.
module program_loader #(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_in_data,
  input  logic         i_in_valid,
  input  logic         i_in_last,
  output logic         o_in_ready,
  output logic         o_mem_we,
  output logic [D-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_core_hold,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [D:0]   o_word_count
);

`ifdef PROGRAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StVerify = 3'd2,
    StDone   = 3'd3,
    StErr    = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StDone = 3'd3,
    StErr  = 3'd4
  } state_e;
`endif

  state_e       r_state;
  state_e       w_state_d;
  logic [D-1:0] r_addr;
  logic [D-1:0] w_addr_d;
  logic [D:0]   r_word_count;
  logic [D:0]   w_word_count_d;
  logic         r_done;
  logic         w_done_d;
  logic         r_error;
  logic         w_error_d;
  logic         r_core_hold;
  logic         w_core_hold_d;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_start_load;

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [W-1:0] r_csum_load;
  logic [W-1:0] w_csum_load_d;
  logic [W-1:0] r_csum_read;
  logic [W-1:0] w_csum_read_d;
  logic [D:0]   r_vcnt;
  logic [D:0]   w_vcnt_d;
  logic [W-1:0] w_csum_final;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_mem_rdata;
`endif

  assign w_accept = i_in_valid & w_in_ready;

  always_comb begin
    w_state_d      = r_state;
    w_addr_d       = r_addr;
    w_word_count_d = r_word_count;
    w_done_d       = r_done;
    w_error_d      = r_error;
    w_core_hold_d  = r_core_hold;
    w_in_ready     = 1'b0;
    w_start_load   = 1'b0;
    o_busy         = 1'b0;
    o_mem_addr     = r_addr;
`ifdef PROGRAM_LOADER_VERIFY_EN
    w_csum_load_d  = r_csum_load;
    w_csum_read_d  = r_csum_read;
    w_vcnt_d       = r_vcnt;
    w_csum_final   = r_csum_read ^ i_mem_rdata;
`endif

    unique case (r_state)
      StIdle: w_start_load = i_start;
      StLoad: begin
        w_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid) begin
          w_addr_d       = r_addr + D'(1);
          w_word_count_d = r_word_count + (D+1)'(1);
`ifdef PROGRAM_LOADER_VERIFY_EN
          w_csum_load_d  = r_csum_load ^ i_in_data;
`endif
          if (i_in_last) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
            w_state_d     = StVerify;
            w_vcnt_d      = '0;
            w_csum_read_d = '0;
`else
            w_state_d     = StDone;
            w_done_d      = 1'b1;
            w_core_hold_d = 1'b0;
`endif
          end else if (&r_addr) begin
            // Last address filled without in_last: image does not fit.
            w_state_d = StErr;
            w_error_d = 1'b1;
          end
        end
      end
`ifdef PROGRAM_LOADER_VERIFY_EN
      StVerify: begin
        o_busy     = 1'b1;
        o_mem_addr = r_vcnt[D-1:0];
        w_vcnt_d   = r_vcnt + (D+1)'(1);
        // Read data lags the address by one cycle, so cycle 0 carries no data.
        if (r_vcnt != '0) begin
          w_csum_read_d = w_csum_final;
        end
        if (r_vcnt == r_word_count) begin
          if (w_csum_final == r_csum_load) begin
            w_state_d     = StDone;
            w_done_d      = 1'b1;
            w_core_hold_d = 1'b0;
          end else begin
            w_state_d = StErr;
            w_error_d = 1'b1;
          end
        end
      end
`endif
      StDone:  w_start_load = i_start;
      StErr:   w_start_load = i_start;
      default: w_state_d = StIdle;
    endcase

    if (w_start_load) begin
      w_state_d      = StLoad;
      w_addr_d       = '0;
      w_word_count_d = '0;
      w_done_d       = 1'b0;
      w_error_d      = 1'b0;
      w_core_hold_d  = 1'b1;
`ifdef PROGRAM_LOADER_VERIFY_EN
      w_csum_load_d  = '0;
      w_csum_read_d  = '0;
`endif
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_hold  <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_word_count <= w_word_count_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_core_hold  <= w_core_hold_d;
    end
  end

`ifdef PROGRAM_LOADER_VERIFY_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_csum_load <= '0;
      r_csum_read <= '0;
      r_vcnt      <= '0;
    end else begin
      r_csum_load <= w_csum_load_d;
      r_csum_read <= w_csum_read_d;
      r_vcnt      <= w_vcnt_d;
    end
  end
`endif

  assign o_in_ready   = w_in_ready;
  assign o_mem_we     = w_accept;
  assign o_mem_wdata  = i_in_data;
  assign o_core_hold  = r_core_hold;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writes a program image into instruction memory from an external word stream. This is the write side of the instruction ROM that the fetch path reads.
- Holds the core in reset (core_hold) until a complete image is loaded, then releases it.
- Sits between the host/testbench stimulus and the instruction memory write port. The program counter and branching unit read the image afterwards.

Parameters:
- D, 12, instruction address width. Matches the program counter and instruction memory.
- W, 9, machine-code word width.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- start  in  1  single-cycle pulse; begins a load
- in_data  in  W  machine-code word from host
- in_valid  in  1  in_data valid
- in_last  in  1  marks final word of image; qualified by in_valid
- in_ready  out  1  block accepts in_data this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  D  instruction memory address (write in LOAD, read in VERIFY)
- mem_wdata  out  W  instruction memory write data
- mem_rdata  in  W  instruction memory read data; synchronous, 1-cycle latency after mem_addr
- core_hold  out  1  1 = core must be held in reset
- busy  out  1  1 in LOAD or VERIFY
- done  out  1  image loaded (and verified if enabled)
- error  out  1  load failed
- word_count  out  D+1  number of words accepted in current/last load

Behaviour:
States: IDLE, LOAD, VERIFY, DONE, ERR.

Reset (reset=0 at edge):
- state=IDLE, core_hold=1, done=0, error=0, busy=0, word_count=0.
- Write address counter=0; mem_we=0.
- Reset mid-LOAD or mid-VERIFY aborts immediately. Memory contents are left as written.

IDLE:
- in_ready=0, mem_we=0.
- start=1 -> LOAD. On that transition: address=0, word_count=0, done=0, error=0, core_hold=1.

LOAD:
- in_ready=1; busy=1.
- Handshake: a word is accepted in the cycle where in_valid & in_ready.
- mem_we = in_valid & in_ready, combinational. mem_addr = address register. mem_wdata = in_data. Zero-latency write.
- On accept: address+1, word_count+1.
- Accept with in_last=1 -> VERIFY if the optional feature is compiled in, else DONE.
- Accept at address 2^D-1 with in_last=0 -> ERR (overflow). That word is still written. word_count = 2^D.
- start during LOAD is ignored.
- in_valid=0 stalls indefinitely; no timeout.

VERIFY:
- Only exists with the optional feature; see below.

DONE:
- done=1, core_hold=0, busy=0, in_ready=0.
- start=1 -> LOAD. core_hold returns to 1 on the next cycle.

ERR:
- error=1, core_hold=1, in_ready=0.
- start=1 -> LOAD, which clears error.

Outputs:
- done, error, core_hold and word_count are registered.
- in_ready and mem_we are decoded from state.
- done and error are never both 1.

Optional Feature:
Macro: PROGRAM_LOADER_VERIFY_EN

With the macro defined:
- During LOAD, keep a W-bit XOR checksum of every accepted word. The checksum is cleared on start.
- After in_last, enter VERIFY: mem_we=0, busy=1. The read address sweeps 0..word_count-1, one address per cycle, driven on mem_addr.
- mem_rdata is XORed into a readback checksum one cycle after each address is presented. VERIFY therefore lasts word_count+1 cycles.
- After the final read data: checksums equal -> DONE; unequal -> ERR.
- start is ignored in VERIFY.

Without the macro:
- No checksum registers, no VERIFY state.
- LOAD goes directly to DONE on the in_last accept.
- mem_rdata is unused.

Test Plan:
1. Reset (reset=0 for 2 cycles) -> core_hold=1, done=0, error=0, in_ready=0, mem_we=0, word_count=0.
2. start; stream 5 words 0x001,0x0A3,0x1FF,0x040,0x155 (last on 0x155) with in_valid always 1:
   - mem_we=1 on 5 consecutive cycles, mem_addr 0..4 with matching data.
   - word_count=5.
   - Without verify: done=1, core_hold=0 the cycle after the last accept.
   - With verify: done=1 after 6 VERIFY cycles.
3. Same image with in_valid toggled 1,0,0,1,... -> writes occur only on valid cycles; addresses remain contiguous 0..4; final state identical to scenario 2.
4. D=4: stream 16 words with in_last=0 -> all 16 written (addresses 0..15), word_count=16, error=1, core_hold=1. A following start clears error and re-enters LOAD.
5. (VERIFY_EN) Memory model corrupts address 2 on readback (bit 0 flipped) -> ERR after VERIFY; error=1, done=0, core_hold=1.
6. reset=0 asserted mid-LOAD after 3 words -> IDLE next cycle, word_count=0, core_hold=1. start pulses in DONE and LOAD: the one in LOAD is ignored, the one in DONE restarts loading.
